// File: rtl/led_pattern_engine.sv
// LED bar pattern generator: bounce, rotate left/right and fill/drain modes
// with a programmable step prescaler, run/hold enable and end-of-sweep pulse.
module led_pattern_engine #(
    parameter int WIDTH = 8,
    parameter int BLK   = 2,
    parameter int DIV_W = 20
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] speed,
    output logic [WIDTH-1:0] led_out,
    output logic             dir,
    output logic             end_pulse
);

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'b00,
        MODE_ROT_L  = 2'b01,
        MODE_ROT_R  = 2'b10,
        MODE_FILL   = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] BLK_LSB  = {{(WIDTH-BLK){1'b0}}, {BLK{1'b1}}};
    localparam logic [WIDTH-1:0] BLK_MSB  = {{BLK{1'b1}}, {(WIDTH-BLK){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_LED  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] ONE_CNT  = {{(DIV_W-1){1'b0}}, 1'b1};

    // Contiguous BLK-wide block anywhere on the bar (bounce reachable set).
    function automatic logic is_block(input logic [WIDTH-1:0] v);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p <= WIDTH - BLK; p++) begin
            if (v == (BLK_LSB << p)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Any circular rotation of the block (rotate reachable set, both directions).
    function automatic logic is_ring(input logic [WIDTH-1:0] v);
        logic             hit;
        logic [WIDTH-1:0] t;
        hit = 1'b0;
        t   = BLK_LSB;
        for (int p = 0; p < WIDTH; p++) begin
            if (v == t) begin
                hit = 1'b1;
            end
            t = {t[WIDTH-2:0], t[WIDTH-1]};
        end
        return hit;
    endfunction

    // Ones packed against the LSB (2^k - 1), the shape seen while filling.
    function automatic logic is_therm_lsb(input logic [WIDTH-1:0] v);
        return ((v & (v + ONE_LED)) == {WIDTH{1'b0}});
    endfunction

    function automatic logic [WIDTH-1:0] start_led(input mode_t m);
        case (m)
            MODE_BOUNCE: return BLK_MSB;
            MODE_ROT_L:  return BLK_LSB;
            MODE_ROT_R:  return BLK_MSB;
            MODE_FILL:   return {WIDTH{1'b0}};
            default:     return BLK_MSB;
        endcase
    endfunction

    mode_t             mode_r;
    logic [DIV_W-1:0]  cnt_r;

    mode_t             mode_s;
    logic [DIV_W-1:0]  cnt_s;
    logic [WIDTH-1:0]  led_s;
    logic              dir_s;
    logic              pulse_s;

    logic [WIDTH-1:0]  step_led_s;
    logic              step_dir_s;
    logic              step_pulse_s;
    logic [WIDTH-1:0]  shift_s;

    // Pattern after one step in the current mode; unreachable values reload the start state.
    always_comb begin
        step_led_s   = start_led(mode_r);
        step_dir_s   = (mode_r == MODE_ROT_R) ? 1'b1 : 1'b0;
        step_pulse_s = 1'b0;
        shift_s      = {WIDTH{1'b0}};
        case (mode_r)
            MODE_BOUNCE: begin
                if (is_block(led_out)) begin
                    shift_s    = dir ? {led_out[WIDTH-2:0], 1'b0} : {1'b0, led_out[WIDTH-1:1]};
                    step_led_s = shift_s;
                    if ((!dir && shift_s == BLK_LSB) || (dir && shift_s == BLK_MSB)) begin
                        step_dir_s   = ~dir;
                        step_pulse_s = 1'b1;
                    end else begin
                        step_dir_s   = dir;
                    end
                end else begin
                    step_dir_s = 1'b0;
                end
            end
            MODE_ROT_L: begin
                if (is_ring(led_out)) begin
                    step_led_s   = {led_out[WIDTH-2:0], led_out[WIDTH-1]};
                    step_pulse_s = (step_led_s == BLK_LSB);
                end else begin
                    step_pulse_s = 1'b0;
                end
            end
            MODE_ROT_R: begin
                if (is_ring(led_out)) begin
                    step_led_s   = {led_out[0], led_out[WIDTH-1:1]};
                    step_pulse_s = (step_led_s == BLK_MSB);
                end else begin
                    step_pulse_s = 1'b0;
                end
            end
            MODE_FILL: begin
                // Drain shapes are ones packed against the MSB, i.e. the complement fills from the LSB.
                if (dir ? is_therm_lsb(~led_out) : is_therm_lsb(led_out)) begin
                    step_led_s = {led_out[WIDTH-2:0], ~dir};
                    step_dir_s = dir;
                    if (!dir && step_led_s == ALL_ONES) begin
                        step_dir_s   = 1'b1;
                        step_pulse_s = 1'b1;
                    end else if (dir && step_led_s == {WIDTH{1'b0}}) begin
                        step_dir_s   = 1'b0;
                        step_pulse_s = 1'b1;
                    end else begin
                        step_pulse_s = 1'b0;
                    end
                end else begin
                    step_dir_s = 1'b0;
                end
            end
            default: begin
                step_led_s = BLK_MSB;
                step_dir_s = 1'b0;
            end
        endcase
    end

    // Mode re-sync has priority over stepping; the prescaler terminal (cnt >= speed) triggers a step.
    always_comb begin
        mode_s  = mode_r;
        cnt_s   = cnt_r;
        led_s   = led_out;
        dir_s   = dir;
        pulse_s = 1'b0;
        if (mode_t'(mode) != mode_r) begin
            mode_s = mode_t'(mode);
            cnt_s  = {DIV_W{1'b0}};
            led_s  = start_led(mode_t'(mode));
            dir_s  = (mode_t'(mode) == MODE_ROT_R) ? 1'b1 : 1'b0;
        end else if (en) begin
            if (cnt_r >= speed) begin
                cnt_s   = {DIV_W{1'b0}};
                led_s   = step_led_s;
                dir_s   = step_dir_s;
                pulse_s = step_pulse_s;
            end else begin
                cnt_s   = cnt_r + ONE_CNT;
            end
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mode_r    <= MODE_BOUNCE;
            cnt_r     <= {DIV_W{1'b0}};
            led_out   <= BLK_MSB;
            dir       <= 1'b0;
            end_pulse <= 1'b0;
        end else begin
            mode_r    <= mode_s;
            cnt_r     <= cnt_s;
            led_out   <= led_s;
            dir       <= dir_s;
            end_pulse <= pulse_s;
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Self-checking bench for led_pattern_engine: per-cycle comparison against a
// sequence-index model plus hand-computed literal expectations.
module tb_led_pattern_engine;

    localparam int W  = 8;
    localparam int B  = 2;
    localparam int DW = 20;

    logic          clk_in = 1'b0;
    logic          reset;
    logic          en;
    logic [1:0]    mode;
    logic [DW-1:0] speed;
    logic [W-1:0]  led_out;
    logic          dir;
    logic          end_pulse;

    int errors = 0;
    int checks = 0;

    led_pattern_engine #(.WIDTH(W), .BLK(B), .DIV_W(DW)) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .en        (en),
        .mode      (mode),
        .speed     (speed),
        .led_out   (led_out),
        .dir       (dir),
        .end_pulse (end_pulse)
    );

    always #5 clk_in = ~clk_in;

    // Each mode is a cyclic list of states; index 0 is the mode's start state.
    function automatic int period(input logic [1:0] md);
        case (md)
            2'd0:    return 2 * (W - B);
            2'd1:    return W;
            2'd2:    return W;
            default: return 2 * W;
        endcase
    endfunction

    function automatic logic [W-1:0] led_at(input logic [1:0] md, input int k);
        logic [W-1:0] lsb_blk;
        logic [W-1:0] msb_blk;
        logic [W-1:0] ones;
        lsb_blk = W'((1 << B) - 1);
        msb_blk = lsb_blk << (W - B);
        ones    = '1;
        case (md)
            2'd0:    return (k <= W - B) ? (lsb_blk << (W - B - k)) : (lsb_blk << (k - (W - B)));
            2'd1:    return (lsb_blk << k) | (lsb_blk >> (W - k));
            2'd2:    return (msb_blk >> k) | (msb_blk << (W - k));
            default: return (k <= W) ? (ones >> (W - k)) : (ones << (k - W));
        endcase
    endfunction

    function automatic logic dir_at(input logic [1:0] md, input int k);
        case (md)
            2'd0:    return (k >= W - B);
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return (k >= W);
        endcase
    endfunction

    function automatic logic pulse_at(input logic [1:0] md, input int k);
        case (md)
            2'd0:    return (k == 0) || (k == W - B);
            2'd1:    return (k == 0);
            2'd2:    return (k == 0);
            default: return (k == 0) || (k == W);
        endcase
    endfunction

    logic [1:0] m_mode;
    int         m_idx;
    int         m_cnt;
    logic       m_pulse;

    // Reference model: prescaler count and position within the mode's cycle.
    always @(posedge clk_in or posedge reset) begin
        if (reset) begin
            m_mode  <= 2'd0;
            m_idx   <= 0;
            m_cnt   <= 0;
            m_pulse <= 1'b0;
        end else if (mode != m_mode) begin
            m_mode  <= mode;
            m_idx   <= 0;
            m_cnt   <= 0;
            m_pulse <= 1'b0;
        end else if (en && m_cnt >= int'(speed)) begin
            m_cnt   <= 0;
            m_idx   <= (m_idx + 1) % period(m_mode);
            m_pulse <= pulse_at(m_mode, (m_idx + 1) % period(m_mode));
        end else begin
            m_cnt   <= en ? m_cnt + 1 : m_cnt;
            m_pulse <= 1'b0;
        end
    end

    task automatic check_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        if (!reset) begin
            check_v("model_led", led_out, led_at(m_mode, m_idx));
            check_b("model_dir", dir, dir_at(m_mode, m_idx));
            check_b("model_pulse", end_pulse, m_pulse);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    logic [W-1:0] held;
    bit           found;

    initial begin
        reset = 1'b1;
        en    = 1'b1;
        mode  = 2'b00;
        speed = '0;
        #12;
        check_v("reset_led", led_out, 8'b11000000);
        check_b("reset_dir", dir, 1'b0);
        check_b("reset_pulse", end_pulse, 1'b0);
        @(posedge clk_in);
        #2;
        reset = 1'b0;

        // bounce, one step per cycle
        tick(6);
        check_v("bounce_lsb_end", led_out, 8'b00000011);
        check_b("bounce_dir_up", dir, 1'b1);
        check_b("bounce_pulse6", end_pulse, 1'b1);
        tick(6);
        check_v("bounce_msb_end", led_out, 8'b11000000);
        check_b("bounce_dir_down", dir, 1'b0);
        check_b("bounce_pulse12", end_pulse, 1'b1);
        tick(1);
        check_v("bounce_wrap", led_out, 8'b01100000);
        check_b("bounce_pulse_low", end_pulse, 1'b0);

        // rotate left, step every 4 cycles
        mode  = 2'b01;
        speed = 20'd3;
        tick(1);
        check_v("rotl_load", led_out, 8'b00000011);
        check_b("rotl_load_pulse", end_pulse, 1'b0);
        tick(28);
        check_v("rotl_step7", led_out, 8'b10000001);
        tick(3);
        check_v("rotl_wait", led_out, 8'b10000001);
        tick(1);
        check_v("rotl_step8", led_out, 8'b00000011);
        check_b("rotl_pulse8", end_pulse, 1'b1);
        tick(1);
        check_b("rotl_pulse_once", end_pulse, 1'b0);

        // rotate right
        mode  = 2'b10;
        speed = '0;
        tick(1);
        check_v("rotr_load", led_out, 8'b11000000);
        check_b("rotr_dir", dir, 1'b1);
        tick(1);
        check_v("rotr_step1", led_out, 8'b01100000);
        tick(7);
        check_v("rotr_back", led_out, 8'b11000000);
        check_b("rotr_pulse", end_pulse, 1'b1);

        // fill / drain
        mode = 2'b11;
        tick(1);
        check_v("fill_load", led_out, 8'b00000000);
        tick(8);
        check_v("fill_full", led_out, 8'b11111111);
        check_b("fill_dir", dir, 1'b1);
        check_b("fill_pulse", end_pulse, 1'b1);
        tick(1);
        check_v("drain_first", led_out, 8'b11111110);
        tick(7);
        check_v("drain_empty", led_out, 8'b00000000);
        check_b("drain_dir", dir, 1'b0);
        check_b("drain_pulse", end_pulse, 1'b1);

        // hold mid-period with speed=9
        mode  = 2'b00;
        speed = 20'd9;
        tick(1);
        tick(15);
        check_v("hold_pre", led_out, 8'b01100000);
        en   = 1'b0;
        held = led_out;
        tick(25);
        check_v("hold_led", led_out, held);
        check_b("hold_dir", dir, 1'b0);
        en = 1'b1;
        tick(4);
        check_v("resume_wait", led_out, 8'b01100000);
        tick(1);
        check_v("resume_step", led_out, 8'b00110000);

        // lowering speed below cnt forces an immediate step
        speed = 20'd100;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_cnt == 50) begin
                found = 1'b1;
            end else begin
                tick(1);
            end
        end
        check_b("cnt50_reached", found, 1'b1);
        speed = 20'd10;
        tick(1);
        check_v("speed_drop_step", led_out, 8'b00011000);
        tick(10);
        check_v("speed_drop_wait", led_out, 8'b00011000);
        tick(1);
        check_v("speed_drop_next", led_out, 8'b00001100);

        // asynchronous reset mid-sweep, then re-sync to mode input
        tick(2);
        #2;
        reset = 1'b1;
        #1;
        check_v("async_reset_led", led_out, 8'b11000000);
        check_b("async_reset_dir", dir, 1'b0);
        check_b("async_reset_pulse", end_pulse, 1'b0);
        mode = 2'b01;
        @(posedge clk_in);
        #2;
        reset = 1'b0;
        tick(1);
        check_v("resync_load", led_out, 8'b00000011);
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
